// File: rtl/win_kernel_xform_pipe_pkg.sv
// ---------------------------------------------------------------------------
// win_pkg: shared constants and types for the Winograd F(2x2,3x3) kernel
// transform pipeline (win_kernel_xform_pipe and win_xform_1d).
//   WIN_M / WIN_R / WIN_T : output tile, kernel and transformed tile sizes
//   MODE_WIDE / MODE_NARROW : per-transaction precision select
//   win_kernel_t / win_tile_t : element arrays at the default element width
//   stg_state_e : occupancy state of one pipeline stage
// Optional feature macro: WIN_XFORM_SAT_EN (saturating arithmetic).
// ---------------------------------------------------------------------------
package win_pkg;

  localparam int WIN_M = 2;
  localparam int WIN_R = 3;
  localparam int WIN_T = 4;

  localparam logic MODE_WIDE   = 1'b0;
  localparam logic MODE_NARROW = 1'b1;

  localparam int WIN_DATA_W = 16;

  typedef logic [WIN_DATA_W-1:0] win_elem_t;
  typedef win_elem_t win_kernel_t [WIN_R][WIN_R];
  typedef win_elem_t win_tile_t   [WIN_T][WIN_T];

  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stg_state_e;

endpackage

// File: rtl/win_kernel_xform_pipe_xform_1d.sv
// ---------------------------------------------------------------------------
// win_xform_1d: combinational 3->4 transform by the rows of
// G = [1 0 0; .5 .5 .5; .5 -.5 .5; 0 0 1] for one element set.
//   mode_i          : 0 = one DATA_W lane, 1 = two independent DATA_W/2 lanes
//   x0_i..x2_i      : input elements (two's complement per lane)
//   y0_o..y3_o      : y0 = x0, y1 = (x0+x1+x2)/2, y2 = (x0-x1+x2)/2, y3 = x2
//   sat_o           : (WIN_XFORM_SAT_EN only) some lane of y1/y2 clamped
// Halving floors (arithmetic shift). Results are clamped with
// WIN_XFORM_SAT_EN and wrapped to lane width otherwise.
// ---------------------------------------------------------------------------
module win_xform_1d
  import win_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              mode_i,
  input  logic [DATA_W-1:0] x0_i,
  input  logic [DATA_W-1:0] x1_i,
  input  logic [DATA_W-1:0] x2_i,
  output logic [DATA_W-1:0] y0_o,
  output logic [DATA_W-1:0] y1_o,
  output logic [DATA_W-1:0] y2_o,
  output logic [DATA_W-1:0] y3_o
`ifdef WIN_XFORM_SAT_EN
  ,
  output logic              sat_o
`endif
);

  localparam int HW = DATA_W / 2;

  // Guard bits above lane width for the three-term sums. Without clamping
  // the top guard bit cannot influence the wrapped result, so only one is kept.
`ifdef WIN_XFORM_SAT_EN
  localparam int GX = 2;
`else
  localparam int GX = 1;
`endif

  // Lane 0: full-width lane (mode 0). Lanes 1/2: low/high half (mode 1).
  // All three are always computed; mode selects which ones reach the outputs.
  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int LW  = (k == 0) ? DATA_W : HW;
    localparam int OFF = (k == 2) ? HW : 0;

    logic [LW-1:0]    a, b, c;
    logic [LW+GX-1:0] sp, sm;
    logic [LW+GX-2:0] hp, hm;
    logic [LW-1:0]    rp, rm;

    assign a = x0_i[OFF +: LW];
    assign b = x1_i[OFF +: LW];
    assign c = x2_i[OFF +: LW];

    assign sp = {{GX{a[LW-1]}}, a} + {{GX{b[LW-1]}}, b} + {{GX{c[LW-1]}}, c};
    assign sm = {{GX{a[LW-1]}}, a} - {{GX{b[LW-1]}}, b} + {{GX{c[LW-1]}}, c};

    // Dropping bit 0 of a two's-complement sum is a floor division by 2.
    assign hp = sp[LW+GX-1:1];
    assign hm = sm[LW+GX-1:1];

`ifdef WIN_XFORM_SAT_EN
    logic ovf_p, ovf_m;
    logic ovf;
    // hp/hm carry one bit above the lane; overflow when it disagrees with the lane sign.
    assign ovf_p = hp[LW] ^ hp[LW-1];
    assign ovf_m = hm[LW] ^ hm[LW-1];
    assign ovf   = ovf_p | ovf_m;
    assign rp = ovf_p ? (hp[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}})
                      : hp[LW-1:0];
    assign rm = ovf_m ? (hm[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}})
                      : hm[LW-1:0];
`else
    assign rp = hp;
    assign rm = hm;
`endif
  end

  assign y0_o = x0_i;
  assign y3_o = x2_i;
  assign y1_o = (mode_i == MODE_NARROW) ? {g_lane[2].rp, g_lane[1].rp} : g_lane[0].rp;
  assign y2_o = (mode_i == MODE_NARROW) ? {g_lane[2].rm, g_lane[1].rm} : g_lane[0].rm;

`ifdef WIN_XFORM_SAT_EN
  assign sat_o = (mode_i == MODE_NARROW) ? (g_lane[1].ovf | g_lane[2].ovf) : g_lane[0].ovf;
`endif

endmodule

// File: rtl/win_kernel_xform_pipe.sv
// ---------------------------------------------------------------------------
// win_kernel_xform_pipe: two-stage pipelined Winograd F(2x2,3x3) kernel
// transform U = G * g * G^T.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : kernel handshake; in_mode, in_kernel (3x3) payload
//   out_valid/out_ready   : tile handshake; out_mode, out_u (4x4) payload
//   sat_flag              : (WIN_XFORM_SAT_EN only) a lane of the tile clamped
// Stage 1 holds B = G*g (4x3, three column transforms); stage 2 holds
// U = B*G^T (4x4, four row transforms) and drives the outputs directly.
// Optional feature macro: WIN_XFORM_SAT_EN.
//
// Handshake: a transfer happens on a cycle where valid & ready are both 1.
// A source holds valid and payload stable until it transfers; ready never
// depends on the same-side valid. Stage 1 advances when stage 2 can take
// its tile, so accept, S1->S2 move and drain can all occur in one cycle.
// ---------------------------------------------------------------------------
module win_kernel_xform_pipe
  import win_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [WIN_R*WIN_R*DATA_W-1:0] in_kernel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_mode,
  output logic [WIN_T*WIN_T*DATA_W-1:0] out_u
`ifdef WIN_XFORM_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int BW = WIN_T * WIN_R * DATA_W;
  localparam int UW = WIN_T * WIN_T * DATA_W;

  stg_state_e    s1_st_q, s2_st_q;
  logic          s1_mode_q, s2_mode_q;
  logic [BW-1:0] s1_b_q, b_d;
  logic [UW-1:0] s2_u_q, u_d;
  logic          s1_v, s2_v, s2_rdy;
  logic          load1, load2, unload2;

  assign s1_v    = (s1_st_q == STG_FULL);
  assign s2_v    = (s2_st_q == STG_FULL);
  assign s2_rdy  = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_rdy;
  assign load1   = in_valid && in_ready;
  assign load2   = s1_v && s2_rdy;
  assign unload2 = s2_v && out_ready;

`ifdef WIN_XFORM_SAT_EN
  logic [WIN_R-1:0] col_sat;
  logic [WIN_T-1:0] row_sat;
  logic             s1_sat_q, s2_sat_q;
`endif

  // Stage 1: B[.][c] = G * g[.][c]
  for (genvar c = 0; c < WIN_R; c++) begin : g_col
    win_xform_1d #(.DATA_W(DATA_W)) u_col (
      .mode_i (in_mode),
      .x0_i   (in_kernel[(0*WIN_R+c)*DATA_W +: DATA_W]),
      .x1_i   (in_kernel[(1*WIN_R+c)*DATA_W +: DATA_W]),
      .x2_i   (in_kernel[(2*WIN_R+c)*DATA_W +: DATA_W]),
      .y0_o   (b_d[(0*WIN_R+c)*DATA_W +: DATA_W]),
      .y1_o   (b_d[(1*WIN_R+c)*DATA_W +: DATA_W]),
      .y2_o   (b_d[(2*WIN_R+c)*DATA_W +: DATA_W]),
      .y3_o   (b_d[(3*WIN_R+c)*DATA_W +: DATA_W])
`ifdef WIN_XFORM_SAT_EN
      ,
      .sat_o  (col_sat[c])
`endif
    );
  end

  // Stage 2: U[i][.] = B[i][.] * G^T, i.e. the same 3->4 transform per row
  for (genvar i = 0; i < WIN_T; i++) begin : g_row
    win_xform_1d #(.DATA_W(DATA_W)) u_row (
      .mode_i (s1_mode_q),
      .x0_i   (s1_b_q[(i*WIN_R+0)*DATA_W +: DATA_W]),
      .x1_i   (s1_b_q[(i*WIN_R+1)*DATA_W +: DATA_W]),
      .x2_i   (s1_b_q[(i*WIN_R+2)*DATA_W +: DATA_W]),
      .y0_o   (u_d[(i*WIN_T+0)*DATA_W +: DATA_W]),
      .y1_o   (u_d[(i*WIN_T+1)*DATA_W +: DATA_W]),
      .y2_o   (u_d[(i*WIN_T+2)*DATA_W +: DATA_W]),
      .y3_o   (u_d[(i*WIN_T+3)*DATA_W +: DATA_W])
`ifdef WIN_XFORM_SAT_EN
      ,
      .sat_o  (row_sat[i])
`endif
    );
  end

  // Stage 1 occupancy and payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_st_q   <= STG_EMPTY;
      s1_mode_q <= MODE_WIDE;
      s1_b_q    <= '0;
`ifdef WIN_XFORM_SAT_EN
      s1_sat_q  <= 1'b0;
`endif
    end else begin
      case (s1_st_q)
        STG_EMPTY: if (load1) s1_st_q <= STG_FULL;
        STG_FULL:  if (!load1 && load2) s1_st_q <= STG_EMPTY;
      endcase
      if (load1) begin
        s1_mode_q <= in_mode;
        s1_b_q    <= b_d;
`ifdef WIN_XFORM_SAT_EN
        s1_sat_q  <= |col_sat;
`endif
      end
    end
  end

  // Stage 2 occupancy and payload; payload only changes on load, so the
  // outputs hold steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_st_q   <= STG_EMPTY;
      s2_mode_q <= MODE_WIDE;
      s2_u_q    <= '0;
`ifdef WIN_XFORM_SAT_EN
      s2_sat_q  <= 1'b0;
`endif
    end else begin
      case (s2_st_q)
        STG_EMPTY: if (load2) s2_st_q <= STG_FULL;
        STG_FULL:  if (!load2 && unload2) s2_st_q <= STG_EMPTY;
      endcase
      if (load2) begin
        s2_mode_q <= s1_mode_q;
        s2_u_q    <= u_d;
`ifdef WIN_XFORM_SAT_EN
        s2_sat_q  <= s1_sat_q | (|row_sat);
`endif
      end
    end
  end

  assign out_valid = s2_v;
  assign out_mode  = s2_mode_q;
  assign out_u     = s2_u_q;
`ifdef WIN_XFORM_SAT_EN
  assign sat_flag  = s2_sat_q;
`endif

endmodule

// File: tb/tb_win_kernel_xform_pipe.sv
// ---------------------------------------------------------------------------
// tb_win_kernel_xform_pipe: self-checking bench for win_kernel_xform_pipe.
// Directed cases (constant tiles, latency, stall/backpressure, mid-flight
// reset) plus randomized traffic against an integer reference model.
// Optional feature macro: WIN_XFORM_SAT_EN.
// ---------------------------------------------------------------------------
module tb_win_kernel_xform_pipe;
  import win_pkg::*;

  localparam int DW = 16;
  localparam int KW = 9 * DW;
  localparam int UW = 16 * DW;
  localparam int EW = UW + 2;   // {sat, mode, u}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_mode;
  logic [KW-1:0] in_kernel;
  logic          out_valid, out_ready, out_mode;
  logic [UW-1:0] out_u;
`ifdef WIN_XFORM_SAT_EN
  logic          sat_flag;
`endif

  win_kernel_xform_pipe #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_kernel (in_kernel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_u     (out_u)
`ifdef WIN_XFORM_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  logic [EW-1:0] exp_q[$];
  logic [UW-1:0] last_u;
  logic          last_sat;
  logic          rand_rdy = 1'b0;
  logic          model_sat;

  task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor_half(input int x);
    return (x >= 0) ? (x / 2) : -((-x + 1) / 2);
  endfunction

  function automatic int reduce(input int x, input int l);
    int m, h, r;
    m = 1 << l;
    h = 1 << (l - 1);
`ifdef WIN_XFORM_SAT_EN
    r = m;
    if (x > h - 1) begin model_sat = 1'b1; return h - 1; end
    if (x < -h)    begin model_sat = 1'b1; return -h; end
    return x + (r - m);
`else
    r = x % m;
    if (r < 0) r += m;
    if (r >= h) r -= m;
    return r;
`endif
  endfunction

  function automatic void xf(input int v0, input int v1, input int v2, input int l,
                             output int y0, output int y1, output int y2, output int y3);
    y0 = v0;
    y1 = reduce(floor_half(v0 + v1 + v2), l);
    y2 = reduce(floor_half(v0 - v1 + v2), l);
    y3 = v2;
  endfunction

  function automatic logic [EW-1:0] model(input logic m, input logic [KW-1:0] k);
    int l, nl, mask, raw;
    int g[3][3];
    int b[4][3];
    int u[4][4];
    logic [KW-1:0] tk;
    logic [UW-1:0] uo, t;
    l  = m ? DW / 2 : DW;
    nl = m ? 2 : 1;
    mask = (1 << l) - 1;
    uo = '0;
    model_sat = 1'b0;
    for (int ln = 0; ln < nl; ln++) begin
      for (int e = 0; e < 9; e++) begin
        tk = k >> (e * DW + ln * l);
        raw = int'(tk[15:0]) & mask;
        if (raw >= (1 << (l - 1))) raw -= (1 << l);
        g[e / 3][e % 3] = raw;
      end
      for (int c = 0; c < 3; c++)
        xf(g[0][c], g[1][c], g[2][c], l, b[0][c], b[1][c], b[2][c], b[3][c]);
      for (int i = 0; i < 4; i++)
        xf(b[i][0], b[i][1], b[i][2], l, u[i][0], u[i][1], u[i][2], u[i][3]);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          t = UW'(u[i][j] & mask);
          uo |= t << ((4 * i + j) * DW + ln * l);
        end
    end
    return {model_sat, m, uo};
  endfunction

  // ---------------- directed constant tables ----------------
  int t_ones[16]   = '{1, 1, 0, 1,  1, 1, 0, 1,  0, 0, 0, 0,  1, 1, 0, 1};
  int t_neg[16]    = '{-1, -2, -1, -1,  -2, -3, -1, -2,  -1, -2, -1, -1,  -1, -2, -1, -1};
`ifdef WIN_XFORM_SAT_EN
  int t_max[16]    = '{'h7FFF, 'h7FFF, 'h3FFF, 'h7FFF,  'h7FFF, 'h7FFF, 'h3FFF, 'h7FFF,
                       'h3FFF, 'h5FFE, 'h1FFF, 'h3FFF,  'h7FFF, 'h7FFF, 'h3FFF, 'h7FFF};
`else
  int t_max[16]    = '{'h7FFF, 'hBFFE, 'h3FFF, 'h7FFF,  'hBFFE, 'h9FFD, 'hDFFF, 'hBFFE,
                       'h3FFF, 'h5FFE, 'h1FFF, 'h3FFF,  'h7FFF, 'hBFFE, 'h3FFF, 'h7FFF};
`endif

  function automatic logic [UW-1:0] tile(input int t[16]);
    logic [UW-1:0] r;
    logic [31:0]   v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v = t[i];
      r[i*DW +: DW] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [KW-1:0] fill(input logic [DW-1:0] v);
    logic [KW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7F80;
      4: return 16'h807F;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [KW-1:0] rand_kernel();
    logic [KW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = rand_elem();
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic m, input logic [KW-1:0] k);
    int n;
    in_valid  = 1'b1;
    in_mode   = m;
    in_kernel = k;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(m, k));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    for (n = 0; n < 300; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d tiles still pending, required 0", name, exp_q.size());
    end
  endtask

  always begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got tile %h, required no tile", out_u);
      end else begin
        e = exp_q.pop_front();
        chk("sb_u", out_u, e[UW-1:0]);
        chk("sb_mode", UW'(out_mode), UW'(e[UW]));
`ifdef WIN_XFORM_SAT_EN
        chk("sb_sat", UW'(sat_flag), UW'(e[UW+1]));
        last_sat = sat_flag;
`else
        last_sat = 1'b0;
`endif
        last_u = out_u;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] k1, k2, k3;
    logic          m1, m2;
    logic [UW-1:0] t_m1, ta, tb;
    int            acc, pop_base;

    in_valid = 1'b0; in_mode = 1'b0; in_kernel = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", UW'(out_valid), '0);
    chk("rst_out_u", out_u, '0);
    chk("rst_out_mode", UW'(out_mode), '0);
`ifdef WIN_XFORM_SAT_EN
    chk("rst_sat_flag", UW'(sat_flag), '0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", UW'(in_ready), UW'(1));

    // All-ones kernel, with exact latency
    in_valid = 1'b1; in_mode = MODE_WIDE; in_kernel = fill(16'h0001);
    @(negedge clk);
    chk("lat_in_ready", UW'(in_ready), UW'(1));
    exp_q.push_back(model(MODE_WIDE, fill(16'h0001)));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", UW'(out_valid), '0);
    @(negedge clk);
    chk("lat_cycle2_valid", UW'(out_valid), UW'(1));
    drain("ones_drain");
    chk("ones_tile", last_u, tile(t_ones));
    chk("ones_sat", UW'(last_sat), '0);

    // All -1: floor halving
    send(MODE_WIDE, fill(16'hFFFF));
    drain("neg_drain");
    chk("neg_tile", last_u, tile(t_neg));

    // All 0x7FFF: overflow handling
    send(MODE_WIDE, fill(16'h7FFF));
    drain("max_drain");
    chk("max_tile", last_u, tile(t_max));
`ifdef WIN_XFORM_SAT_EN
    chk("max_u11", UW'(last_u[5*DW +: DW]), UW'(16'h7FFF));
    chk("max_sat", UW'(last_sat), UW'(1));
`else
    chk("max_u10", UW'(last_u[4*DW +: DW]), UW'(16'hBFFE));
    chk("max_u11", UW'(last_u[5*DW +: DW]), UW'(16'h9FFD));
`endif

    // Narrow mode: low lanes +1, high lanes -1, lanes independent
    ta = tile(t_ones);
    tb = tile(t_neg);
    for (int i = 0; i < 16; i++) t_m1[i*DW +: DW] = {tb[i*DW +: 8], ta[i*DW +: 8]};
    send(MODE_NARROW, fill(16'hFF01));
    drain("narrow_drain");
    chk("narrow_tile", last_u, t_m1);
    chk("narrow_u11", UW'(last_u[5*DW +: DW]), UW'(16'hFD01));

    // Backpressure: in_valid held 4 cycles with out_ready low
    out_ready = 1'b0;
    acc = 0;
    m1 = 1'($urandom_range(0, 1)); k1 = rand_kernel();
    m2 = 1'($urandom_range(0, 1)); k2 = rand_kernel();
    k3 = rand_kernel();
    in_valid = 1'b1; in_mode = m1; in_kernel = k1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(in_mode, in_kernel));
        acc++;
      end
      @(posedge clk); #1;
      if (acc == 1 && in_kernel == k1) begin in_mode = m2; in_kernel = k2; end
      else if (acc == 2 && in_kernel == k2) begin in_mode = MODE_WIDE; in_kernel = k3; end
    end
    chk("stall_accepts", UW'(acc), UW'(2));
    @(negedge clk);
    chk("stall_in_ready", UW'(in_ready), '0);
    chk("stall_out_valid", UW'(out_valid), UW'(1));
    ta = model(m1, k1);
    chk("stall_hold_u0", out_u, ta[UW-1:0]);
    @(negedge clk);
    chk("stall_hold_u1", out_u, ta[UW-1:0]);
    @(posedge clk); #1;
    pop_base = n_pop;
    out_ready = 1'b1;
    send(MODE_WIDE, k3);
    drain("stall_drain");
    chk("stall_pop_count", UW'(n_pop - pop_base), UW'(3));

    // Randomized traffic with random backpressure and mixed modes
    rand_rdy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send(1'($urandom_range(0, 1)), rand_kernel());
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("rand_drain");

    // Reset with two tiles in flight
    out_ready = 1'b0;
    send(MODE_WIDE, rand_kernel());
    send(MODE_NARROW, rand_kernel());
    @(negedge clk);
    chk("prerst_in_ready", UW'(in_ready), '0);
    chk("prerst_out_valid", UW'(out_valid), UW'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", UW'(out_valid), '0);
    exp_q.delete();
    pop_base = n_pop;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("postrst_out_valid", UW'(out_valid), '0);
    end
    chk("postrst_in_ready", UW'(in_ready), UW'(1));
    chk("postrst_no_pop", UW'(n_pop - pop_base), '0);

    // Pipeline still works after reset
    @(posedge clk); #1;
    send(MODE_WIDE, fill(16'h0001));
    drain("postrst_drain");
    chk("postrst_tile", last_u, tile(t_ones));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
